// File: rtl/hh_pkg.sv
// Shared constants and types for the HH neuron scheduler.
// Q9.5 state word format, reset values for V/n/m/h, default spike
// threshold, scheduler FSM state encoding and an index-width helper.
package hh_pkg;

  localparam int unsigned Q_W    = 14;
  localparam int unsigned Q_FRAC = 5;

  localparam logic [Q_W-1:0] V_INIT_D = 14'b110111111_00000; // -65.0
  localparam logic [Q_W-1:0] N_INIT_D = 14'b000000000_01010; // 0.3125
  localparam logic [Q_W-1:0] M_INIT_D = 14'b000000000_00010; // 0.0625
  localparam logic [Q_W-1:0] H_INIT_D = 14'b000000000_10011; // 0.59375
  localparam logic [Q_W-1:0] V_TH_D   = 14'b000000000_00000; // 0.0

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  // Index width for n slots; a single slot still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hh_state_rf.sv
// NUM_N x {V, n, m, h} state register file.
// One combinational read port (raddr -> rd_*), one synchronous write port
// (we/waddr/wr_*). Synchronous active-low reset loads the INIT values.
module hh_state_rf
  import hh_pkg::*;
#(
  parameter int unsigned     NUM_N  = 4,
  parameter int unsigned     W      = Q_W,
  parameter logic [W-1:0]    V_INIT = W'(V_INIT_D),
  parameter logic [W-1:0]    N_INIT = W'(N_INIT_D),
  parameter logic [W-1:0]    M_INIT = W'(M_INIT_D),
  parameter logic [W-1:0]    H_INIT = W'(H_INIT_D)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [idx_w(NUM_N)-1:0]   raddr,
  output logic [W-1:0]              rd_v,
  output logic [W-1:0]              rd_n,
  output logic [W-1:0]              rd_m,
  output logic [W-1:0]              rd_h,
  input  logic                      we,
  input  logic [idx_w(NUM_N)-1:0]   waddr,
  input  logic [W-1:0]              wr_v,
  input  logic [W-1:0]              wr_n,
  input  logic [W-1:0]              wr_m,
  input  logic [W-1:0]              wr_h
);

  logic [W-1:0] v_q [NUM_N];
  logic [W-1:0] n_q [NUM_N];
  logic [W-1:0] m_q [NUM_N];
  logic [W-1:0] h_q [NUM_N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_N; i++) begin
        v_q[i] <= V_INIT;
        n_q[i] <= N_INIT;
        m_q[i] <= M_INIT;
        h_q[i] <= H_INIT;
      end
    end else if (we) begin
      v_q[waddr] <= wr_v;
      n_q[waddr] <= wr_n;
      m_q[waddr] <= wr_m;
      h_q[waddr] <= wr_h;
    end
  end

  assign rd_v = v_q[raddr];
  assign rd_n = n_q[raddr];
  assign rd_m = m_q[raddr];
  assign rd_h = h_q[raddr];

endmodule

// File: rtl/hh_neuron_sched.sv
// Hodgkin-Huxley neuron scheduler: time-multiplexes NUM_N neuron state
// slots over one external update engine. A tick starts a sweep; each slot
// is issued (req_* handshake), its result awaited (rsp_valid), then
// committed with a spike check against V_TH.
// Ports: clk/rst_n (sync, active-low); tick; cur_we/cur_addr/cur_wdata
// stimulus current writes; req_* engine request; rsp_* engine result;
// busy, spike, spike_valid, step_cnt, overrun status.
module hh_neuron_sched
  import hh_pkg::*;
#(
  parameter int unsigned  NUM_N  = 4,
  parameter int unsigned  W      = Q_W,
  parameter logic [W-1:0] V_TH   = W'(V_TH_D),
  parameter logic [W-1:0] V_INIT = W'(V_INIT_D),
  parameter logic [W-1:0] N_INIT = W'(N_INIT_D),
  parameter logic [W-1:0] M_INIT = W'(M_INIT_D),
  parameter logic [W-1:0] H_INIT = W'(H_INIT_D)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    cur_we,
  input  logic [idx_w(NUM_N)-1:0] cur_addr,
  input  logic [W-1:0]            cur_wdata,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [idx_w(NUM_N)-1:0] req_id,
  output logic [W-1:0]            req_v,
  output logic [W-1:0]            req_n,
  output logic [W-1:0]            req_m,
  output logic [W-1:0]            req_h,
  output logic [W-1:0]            req_i,
  input  logic                    rsp_valid,
  input  logic [W-1:0]            rsp_v,
  input  logic [W-1:0]            rsp_n,
  input  logic [W-1:0]            rsp_m,
  input  logic [W-1:0]            rsp_h,
  output logic                    busy,
  output logic [NUM_N-1:0]        spike,
  output logic                    spike_valid,
  output logic [15:0]             step_cnt,
  output logic                    overrun
);

  localparam int unsigned IW = idx_w(NUM_N);
  localparam logic [IW-1:0] LAST = IW'(NUM_N - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    cur_q [NUM_N];
  logic [W-1:0]    hold_v, hold_n, hold_m, hold_h;
  logic [W-1:0]    rd_v, rd_n, rd_m, rd_h;
  logic [NUM_N-1:0] spike_q;
  logic            spike_valid_q;
  logic [15:0]     step_cnt_q;
  logic            overrun_q;
  logic            rf_we;
  logic            last;

  assign last = (idx_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick)      state_d = S_ISSUE;
      S_ISSUE: if (req_ready) state_d = S_WAIT;
      S_WAIT:  if (rsp_valid) state_d = S_WRITE;
      S_WRITE: state_d = last ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; busy as a state decode is cycle-identical to a
  // register set on tick acceptance and cleared on the final commit.
  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b0;
    rf_we     = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_ISSUE: begin req_valid = 1'b1; busy = 1'b1; end
      S_WAIT:  busy = 1'b1;
      S_WRITE: begin busy = 1'b1; rf_we = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: slot index, result holding register, status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      hold_v        <= '0;
      hold_n        <= '0;
      hold_m        <= '0;
      hold_h        <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      step_cnt_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      spike_valid_q <= 1'b0;
      if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (tick) begin
          idx_q   <= '0;
          spike_q <= '0;
        end
        S_ISSUE: ;
        S_WAIT: if (rsp_valid) begin
          hold_v <= rsp_v;
          hold_n <= rsp_n;
          hold_m <= rsp_m;
          hold_h <= rsp_h;
        end
        S_WRITE: begin
          // rd_v still holds the pre-commit V of this slot
          spike_q[idx_q] <= ($signed(rd_v) < $signed(V_TH)) &&
                            ($signed(hold_v) >= $signed(V_TH));
          if (last) begin
            spike_valid_q <= 1'b1;
            step_cnt_q    <= step_cnt_q + 16'd1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stimulus current registers, writable in any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_N; i++) cur_q[i] <= '0;
    end else if (cur_we && (32'(cur_addr) < NUM_N)) begin
      cur_q[cur_addr] <= cur_wdata;
    end
  end

  hh_state_rf #(
    .NUM_N (NUM_N),
    .W     (W),
    .V_INIT(V_INIT),
    .N_INIT(N_INIT),
    .M_INIT(M_INIT),
    .H_INIT(H_INIT)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .raddr(idx_q),
    .rd_v (rd_v),
    .rd_n (rd_n),
    .rd_m (rd_m),
    .rd_h (rd_h),
    .we   (rf_we),
    .waddr(idx_q),
    .wr_v (hold_v),
    .wr_n (hold_n),
    .wr_m (hold_m),
    .wr_h (hold_h)
  );

  assign req_id      = idx_q;
  assign req_v       = rd_v;
  assign req_n       = rd_n;
  assign req_m       = rd_m;
  assign req_h       = rd_h;
  assign req_i       = cur_q[idx_q];
  assign spike       = spike_q;
  assign spike_valid = spike_valid_q;
  assign step_cnt    = step_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hh_neuron_sched.sv
// Self-checking bench for hh_neuron_sched: table of sweep records with
// per-sweep engine responses and expected results, plus a hand-written
// mid-sweep reset sequence.
module tb_hh_neuron_sched;

  localparam logic [13:0] VI  = 14'h37E0; // -65.0
  localparam logic [13:0] NI  = 14'h000A; // 0.3125
  localparam logic [13:0] MI  = 14'h0002; // 0.0625
  localparam logic [13:0] HI  = 14'h0013; // 0.59375
  localparam logic [13:0] P10 = 14'h0140; // +10.0

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        cur_we = 1'b0;
  logic [1:0]  cur_addr = '0;
  logic [13:0] cur_wdata = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [1:0]  req_id;
  logic [13:0] req_v, req_n, req_m, req_h, req_i;
  logic        rsp_valid = 1'b0;
  logic [13:0] rsp_v = '0, rsp_n = '0, rsp_m = '0, rsp_h = '0;
  logic        busy;
  logic [3:0]  spike;
  logic        spike_valid;
  logic [15:0] step_cnt;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  hh_neuron_sched #(.NUM_N(4), .W(14)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_wdata(cur_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_v(req_v), .req_n(req_n), .req_m(req_m), .req_h(req_h), .req_i(req_i),
    .rsp_valid(rsp_valid), .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_m(rsp_m), .rsp_h(rsp_h),
    .busy(busy), .spike(spike), .spike_valid(spike_valid),
    .step_cnt(step_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cur3_we;
    logic [13:0] cur3;
    int          stall0;    // ready-low cycles for id 0
    int          tick_wait; // id during whose WAIT a tick is pulsed, -1 none
    logic [13:0] ei0, ei3;  // expected req_i for ids 0 and 3
    logic [13:0] rv2, rn2, rm2, rh2; // engine result for id 2
    logic [13:0] ev2, en2, em2, eh2; // expected request state for id 2
    logic [3:0]  exp_spike;
    logic [15:0] exp_cnt;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Engine side for one slot: wait for request, check it, optional stall,
  // handshake, optional overlapping tick, then return the result.
  task automatic serve(input int id, input vec_t v, input bit abort);
    int k;
    logic [13:0] xv, xn, xm, xh, xi;
    xv = (id == 2) ? v.ev2 : VI;
    xn = (id == 2) ? v.en2 : NI;
    xm = (id == 2) ? v.em2 : MI;
    xh = (id == 2) ? v.eh2 : HI;
    xi = (id == 0) ? v.ei0 : (id == 3) ? v.ei3 : 14'h0;
    k = 0;
    while (!req_valid && k < 50) begin
      step();
      k++;
    end
    chk("req_valid_wait", req_valid, 1);
    chk("req_id", req_id, id);
    chk("req_v", req_v, xv);
    chk("req_n", req_n, xn);
    chk("req_m", req_m, xm);
    chk("req_h", req_h, xh);
    chk("req_i", req_i, xi);
    if (id == 0) begin
      for (int d = 0; d < v.stall0; d++) begin
        req_ready = 1'b0;
        if (d == 1) begin
          cur_we = 1'b1; cur_addr = 2'd0; cur_wdata = 14'h0007;
        end
        step();
        cur_we = 1'b0;
        chk("stall_req_valid", req_valid, 1);
        chk("stall_req_id", req_id, id);
        chk("stall_req_v", req_v, xv);
        chk("stall_req_h", req_h, xh);
        chk("stall_req_i", req_i, (d >= 1) ? 14'h0007 : xi);
      end
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("req_valid_after_hs", req_valid, 0);
    if (abort) return;
    if (v.tick_wait == id) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("overrun_set", overrun, 1);
      chk("busy_in_wait", busy, 1);
    end
    rsp_v = (id == 2) ? v.rv2 : xv;
    rsp_n = (id == 2) ? v.rn2 : xn;
    rsp_m = (id == 2) ? v.rm2 : xm;
    rsp_h = (id == 2) ? v.rh2 : xh;
    rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    step();
    if (id != 3) chk("spike_valid_mid", spike_valid, 0);
  endtask

  task automatic run_sweep(input vec_t v);
    if (v.cur3_we) begin
      cur_we = 1'b1; cur_addr = 2'd3; cur_wdata = v.cur3;
      step();
      cur_we = 1'b0;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("busy_start", busy, 1);
    chk("req_valid_start", req_valid, 1);
    chk("spike_cleared", spike, 0);
    for (int id = 0; id < 4; id++) serve(id, v, 1'b0);
    chk("spike_valid_end", spike_valid, 1);
    chk("spike", spike, v.exp_spike);
    chk("step_cnt", step_cnt, v.exp_cnt);
    chk("busy_end", busy, 0);
    chk("overrun", overrun, v.exp_ovr);
    step();
    chk("spike_valid_pulse", spike_valid, 0);
    chk("spike_hold", spike, v.exp_spike);
    chk("busy_idle", busy, 0);
    chk("step_cnt_hold", step_cnt, v.exp_cnt);
  endtask

  initial begin
    vec_t rv;
    //          we    cur3 stl tw  ei0      ei3  rv2  rn2       rm2       rh2       ev2  en2       em2       eh2       spk      cnt    ovr
    vecs[0] = '{1'b0, 14'h0, 0, -1, 14'h0,   14'h0, VI,  NI,       MI,       HI,       VI,  NI,       MI,       HI,       4'b0000, 16'd1, 1'b0};
    vecs[1] = '{1'b0, 14'h0, 5, -1, 14'h0,   14'h0, P10, 14'h0055, 14'h0123, 14'h0456, VI,  NI,       MI,       HI,       4'b0100, 16'd2, 1'b0};
    vecs[2] = '{1'b0, 14'h0, 0, -1, 14'h7,   14'h0, P10, 14'h0055, 14'h0123, 14'h0456, P10, 14'h0055, 14'h0123, 14'h0456, 4'b0000, 16'd3, 1'b0};
    vecs[3] = '{1'b1, P10,   0,  1, 14'h7,   P10,   P10, 14'h0055, 14'h0123, 14'h0456, P10, 14'h0055, 14'h0123, 14'h0456, 4'b0000, 16'd4, 1'b1};
    vecs[4] = '{1'b0, 14'h0, 0, -1, 14'h0,   14'h0, VI,  NI,       MI,       HI,       VI,  NI,       MI,       HI,       4'b0000, 16'd1, 1'b0};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_spike", spike, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_req_v", req_v, VI);
    chk("rst_req_n", req_n, NI);
    chk("rst_req_m", req_m, MI);
    chk("rst_req_h", req_h, HI);
    chk("rst_req_i", req_i, 0);

    for (int s = 0; s < 4; s++) run_sweep(vecs[s]);

    // Reset during WAIT of id 2, followed by a late engine result
    rv = vecs[3];
    rv.tick_wait = -1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    serve(0, rv, 1'b0);
    serve(1, rv, 1'b0);
    serve(2, rv, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rsp_v = P10; rsp_n = 14'h0055; rsp_m = 14'h0123; rsp_h = 14'h0456;
    rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("abort_busy", busy, 0);
      chk("abort_spike_valid", spike_valid, 0);
      chk("abort_step_cnt", step_cnt, 0);
      chk("abort_overrun", overrun, 0);
      chk("abort_req_valid", req_valid, 0);
      step();
    end
    chk("abort_req_v", req_v, VI);
    chk("abort_req_i", req_i, 0);

    run_sweep(vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
